wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Architectural integer register file. It is the consuming end of the writeback interface driven by the MEM/WB pipeline register.
- Accepts one write per cycle from WB (write-enable, destination address, data).
- Serves two read ports to the ID stage, with same-cycle write-to-read bypass.
- x0 is hardwired to zero.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; the file holds 2**ADDR_W entries.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global ready; when low, the write is suppressed and the file holds state.
- we  in  1  write enable from WB (wb_wreg).
- waddr  in  ADDR_W  write destination register (wb_wd).
- wdata  in  DATA_W  write data (wb_data).
- re1  in  1  read-port-1 enable from ID.
- raddr1  in  ADDR_W  read-port-1 register address.
- rdata1  out  DATA_W  read-port-1 data, combinational.
- re2  in  1  read-port-2 enable from ID.
- raddr2  in  ADDR_W  read-port-2 register address.
- rdata2  out  DATA_W  read-port-2 data, combinational.

Behaviour:
- Storage: regs[0 .. 2**ADDR_W-1], each DATA_W bits.
- Reset (rst low, asynchronous):
  - All entries clear to 0 immediately, without waiting for a clock edge.
  - rdata1 and rdata2 are forced to 0 for as long as rst is low.
  - Release is synchronous to the next clk edge; the first write can land on the first rising edge with rst high.
- Write commit condition: all of rst high, rdy high, we = 1, waddr != 0.
  - When met, regs[waddr] <= wdata at the rising clk edge. Write latency is 1 cycle; the value is visible from the stored array the cycle after.
  - Otherwise no entry changes.
- Write to x0: always discarded; regs[0] stays 0 permanently.
- rdy low: writes are dropped, not queued. The upstream pipeline register already zeroes we under the same condition, so no data is lost.
- Read port n (n = 1, 2), priority order, evaluated combinationally every cycle:
  1. rst low -> 0.
  2. ren = 0 -> 0.
  3. raddrn = 0 -> 0.
  4. Bypass when we = 1, rdy = 1 and raddrn == waddr -> wdata (same-cycle WB to ID forwarding).
  5. Otherwise -> regs[raddrn].
- Bypass qualification: bypass is active exactly when a commit would occur. A dropped write (rdy low, or waddr = 0) is never forwarded.
- Independent ports: both ports may address the same register, or both may hit the bypass in the same cycle; each returns the same value.
- Timing:
  - No combinational path from rdata to any input besides the read-mux cone.
  - No read-side state; read latency is 0 cycles.
- Width rules:
  - No arithmetic.
  - All address compares are full ADDR_W equality.
  - wdata is stored unmodified.
- Mid-operation reset: asserting rst while we is high loses that write; the array reads all-zero afterwards.

Decomposition:
- Shared package / defines header:
  - DATA_W and ADDR_W defaults, via the existing RegBus / RegAddrBus widths.
  - ZERO_WORD constant.
  - REG_ZERO address constant (0).
  - Read/write enable and disable encodings.
- Natural sub-module: regfile_rd_port. One instance per read port, holding the priority mux of rules 1-5 above. Instantiated twice, sharing the storage array and the write-bus signals.

Test Plan:
- Async reset: with rst high, write x5 = 0x1234_5678. Pull rst low mid-cycle -> rdata1 (re1 = 1, raddr1 = 5) reads 0 immediately, before any clk edge. After release, x5 still reads 0.
- Basic write/read: we = 1, waddr = 10, wdata = 0xDEAD_BEEF, rdy = 1; next cycle we = 0, re1 = 1, raddr1 = 10 -> rdata1 = 0xDEAD_BEEF. With re1 = 0 -> rdata1 = 0.
- x0 immutability: we = 1, waddr = 0, wdata = 0xFFFF_FFFF. The same cycle and the next, re1 = re2 = 1 with raddr = 0 -> both outputs 0.
- Bypass on both ports: x7 holds 0x11; drive we = 1, waddr = 7, wdata = 0x22, re1 = re2 = 1, raddr1 = raddr2 = 7 -> both read 0x22 in the same cycle. Next cycle with we = 0 -> both still 0x22.
- rdy stall: x3 = 0xAAAA; rdy = 0, we = 1, waddr = 3, wdata = 0x5555, re1 = 1, raddr1 = 3 -> rdata1 = 0xAAAA (no bypass). After rdy returns high with we = 0 -> still 0xAAAA.
- Port independence: x1 = 0x100, x2 = 0x200; raddr1 = 1, raddr2 = 2, with a concurrent write x2 = 0x300 -> rdata1 = 0x100, rdata2 = 0x300.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and enable encodings for the writeback register file.
// Widths mirror the pipeline's RegBus / RegAddrBus definitions.
package wb_regfile_pkg;

    localparam int REG_BUS_W      = 32;
    localparam int REG_ADDR_BUS_W = 5;

    localparam logic [REG_BUS_W-1:0]      ZERO_WORD = '0;
    localparam logic [REG_ADDR_BUS_W-1:0] REG_ZERO  = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic READ_ENABLE   = 1'b1;
    localparam logic READ_DISABLE  = 1'b0;

endpackage : wb_regfile_pkg

// File: rtl/wb_regfile_rd_port.sv
// One combinational read port: reset/enable/x0 gating, WB bypass, then array lookup.
// The caller guarantees the bypass qualifiers match the write commit condition.
module wb_regfile_rd_port
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_BUS_W,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic                          rst,
    input  logic                          re,
    input  logic [ADDR_W-1:0]             raddr,
    input  logic                          we,
    input  logic                          rdy,
    input  logic [ADDR_W-1:0]             waddr,
    input  logic [DATA_W-1:0]             wdata,
    input  logic [NREGS-1:0][DATA_W-1:0]  regs,
    output logic [DATA_W-1:0]             rdata
);

    logic addr_zero;
    logic bypass_hit;

    always_comb begin
        addr_zero  = (raddr == ADDR_W'(REG_ZERO));
        // raddr != 0 is already required before this matters, so waddr != 0 is implied.
        bypass_hit = (we == WRITE_ENABLE) && rdy && (raddr == waddr);
    end

    always_comb begin
        rdata = '0;
        if (!rst) begin
            rdata = '0;
        end else if (re == READ_DISABLE) begin
            rdata = '0;
        end else if (addr_zero) begin
            rdata = '0;
        end else if (bypass_hit) begin
            rdata = wdata;
        end else begin
            rdata = regs[raddr];
        end
    end

endmodule : wb_regfile_rd_port

// File: rtl/wb_regfile.sv
// Architectural integer register file: one WB write per cycle, two ID read ports
// with same-cycle write-to-read forwarding; x0 is hardwired to zero.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2
);

    localparam int NREGS = 1 << ADDR_W;

    logic [NREGS-1:0][DATA_W-1:0] regs_q;
    logic [NREGS-1:0][DATA_W-1:0] regs_d;
    logic                         commit;

    // rst is folded in so the commit term is also the exact bypass qualifier.
    always_comb begin
        commit = rst && rdy && (we == WRITE_ENABLE) && (waddr != ADDR_W'(REG_ZERO));
    end

    always_comb begin
        regs_d = regs_q;
        if (commit) begin
            regs_d[waddr] = wdata;
        end
        regs_d[0] = '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    wb_regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd_port1 (
        .rst   (rst),
        .re    (re1),
        .raddr (raddr1),
        .we    (we),
        .rdy   (rdy),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs_q),
        .rdata (rdata1)
    );

    wb_regfile_rd_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_rd_port2 (
        .rst   (rst),
        .re    (re2),
        .raddr (raddr2),
        .we    (we),
        .rdy   (rdy),
        .waddr (waddr),
        .wdata (wdata),
        .regs  (regs_q),
        .rdata (rdata2)
    );

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, x0, bypass, stall and port independence.
module tb_wb_regfile;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              re1;
    logic [ADDR_W-1:0] raddr1;
    logic [DATA_W-1:0] rdata1;
    logic              re2;
    logic [ADDR_W-1:0] raddr2;
    logic [DATA_W-1:0] rdata2;

    int checks = 0;
    int errors = 0;

    wb_regfile #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .rdy    (rdy),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .re1    (re1),
        .raddr1 (raddr1),
        .rdata1 (rdata1),
        .re2    (re2),
        .raddr2 (raddr2),
        .rdata2 (rdata2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd10;
        #1;
        chk("reset_rdata1", rdata1, 32'h0);
        chk("reset_rdata2", rdata2, 32'h0);
        tick();
        rst = 1'b1;
        tick();

        // Async reset: store x5, then drop rst mid-cycle.
        do_write(5'd5, 32'h1234_5678);
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        chk("x5_stored", rdata1, 32'h1234_5678);
        #1;
        rst = 1'b0;
        #1;
        chk("async_reset_immediate", rdata1, 32'h0);
        tick();
        rst = 1'b1;
        #1;
        chk("x5_after_reset", rdata1, 32'h0);
        tick();
        chk("x5_after_reset_edge", rdata1, 32'h0);

        // Basic write/read and read-enable gating.
        re1 = 1'b0;
        do_write(5'd10, 32'hDEAD_BEEF);
        re1 = 1'b1; raddr1 = 5'd10;
        #1;
        chk("x10_read", rdata1, 32'hDEAD_BEEF);
        re1 = 1'b0;
        #1;
        chk("x10_re_off", rdata1, 32'h0);

        // x0 immutability, same cycle and next.
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd0; raddr2 = 5'd0;
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
        #1;
        chk("x0_same_cycle_p1", rdata1, 32'h0);
        chk("x0_same_cycle_p2", rdata2, 32'h0);
        tick();
        we = 1'b0;
        #1;
        chk("x0_next_p1", rdata1, 32'h0);
        chk("x0_next_p2", rdata2, 32'h0);

        // Bypass on both ports.
        do_write(5'd7, 32'h11);
        raddr1 = 5'd7; raddr2 = 5'd7;
        #1;
        chk("x7_old_p1", rdata1, 32'h11);
        we = 1'b1; waddr = 5'd7; wdata = 32'h22;
        #1;
        chk("bypass_p1", rdata1, 32'h22);
        chk("bypass_p2", rdata2, 32'h22);
        re1 = 1'b0;
        #1;
        chk("bypass_re_off", rdata1, 32'h0);
        re1 = 1'b1;
        tick();
        we = 1'b0;
        #1;
        chk("x7_new_p1", rdata1, 32'h22);
        chk("x7_new_p2", rdata2, 32'h22);

        // rdy stall: write dropped, no forwarding.
        do_write(5'd3, 32'hAAAA);
        rdy = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'h5555;
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        chk("stall_no_bypass", rdata1, 32'hAAAA);
        tick();
        rdy = 1'b1; we = 1'b0;
        #1;
        chk("stall_no_commit", rdata1, 32'hAAAA);

        // Port independence with concurrent write to one port's register.
        do_write(5'd1, 32'h100);
        do_write(5'd2, 32'h200);
        raddr1 = 5'd1; raddr2 = 5'd2;
        we = 1'b1; waddr = 5'd2; wdata = 32'h300;
        #1;
        chk("indep_p1", rdata1, 32'h100);
        chk("indep_p2_bypass", rdata2, 32'h300);
        tick();
        we = 1'b0;
        #1;
        chk("indep_p1_after", rdata1, 32'h100);
        chk("indep_p2_after", rdata2, 32'h300);

        // Earlier entries survive unrelated writes.
        raddr1 = 5'd10; raddr2 = 5'd3;
        #1;
        chk("x10_retained", rdata1, 32'hDEAD_BEEF);
        chk("x3_retained", rdata2, 32'hAAAA);

        // Reset while a write is in flight loses it and clears the array.
        raddr1 = 5'd9; raddr2 = 5'd10;
        we = 1'b1; waddr = 5'd9; wdata = 32'hCAFE_F00D;
        #1;
        rst = 1'b0;
        #1;
        chk("midop_reset_p1", rdata1, 32'h0);
        tick();
        we = 1'b0;
        rst = 1'b1;
        #1;
        chk("midop_x9_lost", rdata1, 32'h0);
        chk("midop_x10_cleared", rdata2, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_wb_regfile
